addsub_rr_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one Q24.8 fixed-point add/subtract datapath among N_REQ requesters in the 4D gradient-descent engine. Typical requesters are the per-dimension parameter-update lanes. Each accepted request carries two 32-bit signed operands and an add/sub select. Exactly two cycles after acceptance, the block returns a saturated or wrapped result, an overflow flag and the requester's ID, with a one-hot response strobe. A sticky overflow status is available for the top-level controller.

---
 rtl/addsub_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_addsub_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin arbiter that shares one fixed-point add/subtract
// datapath among N_REQ requesters. A request accepted on one edge is held in
// stage 1. On the next edge its result lands in stage 2, which drives the response.
// Overflow either saturates the result (SAT=1) or wraps it (SAT=0).
module addsub_rr_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter bit          SAT    = 1'b1,
    localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ-1:0]        req_sub,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [IW-1:0]           rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_ovf,
    output logic                    busy,
    output logic                    ovf_sticky,
    input  logic                    ovf_clr
);

    // Round-robin pointer: index of the most recent grant
    logic [IW-1:0]     ptr_q, ptr_d;

    // Stage 1: captured request
    logic              s1_valid_q;
    logic [IW-1:0]     s1_id_q;
    logic [DATA_W-1:0] s1_a_q, s1_b_q;
    logic              s1_sub_q;

    // Stage 2: result registers, which drive the response outputs directly
    logic              s2_valid_q;
    logic [IW-1:0]     rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q, res_d;
    logic              rsp_ovf_q, ovf_d;
    logic              sticky_q, sticky_d;

    logic              grant_any;
    logic [IW-1:0]     grant_idx;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_sub;
    logic [DATA_W:0]   wide;

    // Arbitration: first valid index searching upward from ptr+1. The grant is
    // masked while reset is asserted so that req_ready reads 0 during reset.
    always_comb begin
        int unsigned cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_q) + k) % N_REQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IW'(cand);
            end
        end
        grant_any = grant_any & arb_en & rst_n;
        req_ready = grant_any ? (N_REQ'(1) << grant_idx) : '0;
        ptr_d     = grant_any ? grant_idx : ptr_q;
        sel_a     = req_a[32'(grant_idx)*DATA_W +: DATA_W];
        sel_b     = req_b[32'(grant_idx)*DATA_W +: DATA_W];
        sel_sub   = req_sub[grant_idx];
    end

    // Datapath: sign-extended DATA_W+1-bit add/sub, followed by saturate or wrap
    always_comb begin
        if (s1_sub_q)
            wide = {s1_a_q[DATA_W-1], s1_a_q} - {s1_b_q[DATA_W-1], s1_b_q};
        else
            wide = {s1_a_q[DATA_W-1], s1_a_q} + {s1_b_q[DATA_W-1], s1_b_q};
        ovf_d = wide[DATA_W] ^ wide[DATA_W-1];
        res_d = wide[DATA_W-1:0];
        if (SAT && ovf_d)
            res_d = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
        // Setting the flag takes priority over a clear on the same edge
        sticky_d = sticky_q;
        if (s1_valid_q && ovf_d)
            sticky_d = 1'b1;
        else if (ovf_clr)
            sticky_d = 1'b0;
    end

    // Pointer and stage 1 capture on the transfer edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IW'(N_REQ - 1);
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sub_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= grant_any;
            if (grant_any) begin
                s1_id_q  <= grant_idx;
                s1_a_q   <= sel_a;
                s1_b_q   <= sel_b;
                s1_sub_q <= sel_sub;
            end
        end
    end

    // Stage 2: result payload updates only for valid entries, otherwise it holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            sticky_q   <= sticky_d;
            if (s1_valid_q) begin
                rsp_id_q   <= s1_id_q;
                rsp_data_q <= res_d;
                rsp_ovf_q  <= ovf_d;
            end
        end
    end

    // Response strobe and status outputs
    always_comb begin
        rsp_valid  = s2_valid_q ? (N_REQ'(1) << rsp_id_q) : '0;
        rsp_id     = rsp_id_q;
        rsp_data   = rsp_data_q;
        rsp_ovf    = rsp_ovf_q;
        busy       = s1_valid_q | s2_valid_q;
        ovf_sticky = sticky_q;
    end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed testbench for addsub_rr_arbiter. Instance u_dut saturates and
// instance u_wrap wraps; both are driven by the same stimulus.
module tb_addsub_rr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           arb_en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_sub;
    logic           ovf_clr;

    logic [N-1:0]   req_ready, rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ovf, busy, ovf_sticky;

    logic [N-1:0]   w_ready, w_valid;
    logic [1:0]     w_id;
    logic [W-1:0]   w_data;
    logic           w_ovf, w_busy, w_sticky;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.N_REQ(N), .DATA_W(W), .SAT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
        .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .busy(busy), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    addsub_rr_arbiter #(.N_REQ(N), .DATA_W(W), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
        .req_ready(w_ready), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(w_valid), .rsp_id(w_id), .rsp_data(w_data),
        .rsp_ovf(w_ovf), .busy(w_busy), .ovf_sticky(w_sticky), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_sub[i]       = sub;
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_ready"},  req_ready, 0);
        chk({tag, "_rspv"},   rsp_valid, 0);
        chk({tag, "_id"},     rsp_id, 0);
        chk({tag, "_data"},   rsp_data, 0);
        chk({tag, "_ovf"},    rsp_ovf, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_sticky"}, ovf_sticky, 0);
    endtask

    initial begin
        rst_n = 1'b0; arb_en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        req_sub = '0; ovf_clr = 1'b0;

        // Reset: every output reads 0 even when a request is pending
        set_req(0, 32'h1, 32'h1, 1'b0);
        step();
        #1;
        chk_rst_outputs("reset");
        req_valid = '0;
        step();
        rst_n = 1'b1;

        // Single add on requester 0: 1.5 + 2.25 = 3.75
        set_req(0, 32'h0000_0180, 32'h0000_0240, 1'b0);
        #1 chk("add_ready", req_ready, 4'b0001);
        step(); req_valid = '0;
        chk("add_lat_rspv", rsp_valid, 0);
        chk("add_lat_busy", busy, 1);
        step();
        chk("add_rspv", rsp_valid, 4'b0001);
        chk("add_data", rsp_data, 32'h0000_03C0);
        chk("add_ovf", rsp_ovf, 0);
        chk("add_sticky", ovf_sticky, 0);
        step();
        chk("add_after_rspv", rsp_valid, 0);
        chk("add_after_busy", busy, 0);
        chk("add_hold_data", rsp_data, 32'h0000_03C0);

        // Positive saturation on requester 2; pointer is now 0
        set_req(2, 32'h7FFF_FF00, 32'h0000_0100, 1'b0);
        #1 chk("psat_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        step();
        chk("psat_rspv", rsp_valid, 4'b0100);
        chk("psat_id", rsp_id, 2);
        chk("psat_data", rsp_data, 32'h7FFF_FFFF);
        chk("psat_ovf", rsp_ovf, 1);
        chk("psat_sticky", ovf_sticky, 1);
        chk("psat_wrap_data", w_data, 32'h8000_0000);

        // ovf_clr coinciding with a non-overflow result; pointer 2, so requester 1 is granted
        set_req(1, 32'h1, 32'h1, 1'b0);
        #1 chk("clr_ready", req_ready, 4'b0010);
        step(); req_valid = '0; ovf_clr = 1'b1;
        step(); ovf_clr = 1'b0;
        chk("clr_rspv", rsp_valid, 4'b0010);
        chk("clr_data", rsp_data, 32'h2);
        chk("clr_ovf", rsp_ovf, 0);
        chk("clr_sticky", ovf_sticky, 0);

        // Negative saturation via subtract on requester 3
        set_req(3, 32'h8000_0000, 32'h0000_0100, 1'b1);
        #1 chk("nsat_ready", req_ready, 4'b1000);
        step(); req_valid = '0;
        step();
        chk("nsat_rspv", rsp_valid, 4'b1000);
        chk("nsat_data", rsp_data, 32'h8000_0000);
        chk("nsat_ovf", rsp_ovf, 1);
        chk("nsat_sticky", ovf_sticky, 1);
        chk("nsat_wrap_data", w_data, 32'h7FFF_FF00);
        chk("nsat_wrap_ovf", w_ovf, 1);

        // ovf_clr on the same edge as an overflow result: set wins
        set_req(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        #1 chk("coll_ready", req_ready, 4'b0001);
        step(); req_valid = '0; ovf_clr = 1'b1;
        step();
        chk("coll_ovf", rsp_ovf, 1);
        chk("coll_sticky", ovf_sticky, 1);
        chk("coll_wrap_data", w_data, 32'h8000_0000);
        step(); ovf_clr = 1'b0;
        chk("clr_idle_sticky", ovf_sticky, 0);

        // arb_en dropped with two entries in flight; pointer 0
        set_req(1, 32'h10, 32'h5, 1'b1);
        #1 chk("drain_ready1", req_ready, 4'b0010);
        step(); req_valid = '0;
        set_req(2, 32'h3, 32'h4, 1'b0);
        #1 chk("drain_ready2", req_ready, 4'b0100);
        step(); req_valid = '0;
        arb_en = 1'b0;
        set_req(3, 32'h0, 32'h0, 1'b0);
        #1 chk("drain_noready", req_ready, 0);
        chk("drain_rspv1", rsp_valid, 4'b0010);
        chk("drain_data1", rsp_data, 32'hB);
        step();
        chk("drain_rspv2", rsp_valid, 4'b0100);
        chk("drain_data2", rsp_data, 32'h7);
        chk("drain_busy2", busy, 1);
        chk("drain_noready2", req_ready, 0);
        step();
        chk("drain_done_rspv", rsp_valid, 0);
        chk("drain_done_busy", busy, 0);
        arb_en = 1'b1;
        #1 chk("reen_ready", req_ready, 4'b1000);
        step(); req_valid = '0;
        step();
        chk("reen_rspv", rsp_valid, 4'b1000);
        chk("reen_id", rsp_id, 3);

        // Async reset one cycle after a transfer; pointer 3, so requester 1 is granted
        step();
        set_req(1, 32'h1, 32'h1, 1'b0);
        #1 chk("rst_xfer_ready", req_ready, 4'b0010);
        step(); req_valid = '0;
        #3 rst_n = 1'b0;
        set_req(3, 32'h1, 32'h1, 1'b0);
        #1 chk_rst_outputs("midrst");
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_rspv", rsp_valid, 0);
            step();
        end

        // Fairness: all requesters valid for 8 grants, answered in grant order
        for (int i = 0; i < 4; i++) set_req(i, 32'(i * 256), 32'h10, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) chk("fair_ready", req_ready, 4'b0001 << (c % 4));
            else       chk("fair_ready_off", req_ready, 0);
            if (c >= 2) begin
                chk("fair_rspv", rsp_valid, 4'b0001 << ((c - 2) % 4));
                chk("fair_id", rsp_id, (c - 2) % 4);
                chk("fair_data", rsp_data, ((c - 2) % 4) * 256 + 16);
            end else begin
                chk("fair_rspv_early", rsp_valid, 0);
            end
            step();
        end
        step();
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
